// File: rtl/uc_loader_pkg.sv
// Shared types and constants for the unit-clause load path.
//   uc_arb_t     : arbiter phase encoding
//   uc_ld_t      : uc_loader FSM states
//   LIT_IDX_MAX  : largest legal variable index
//   LIT_W        : signed literal width, derived from LIT_IDX_MAX
//   lit_in_range : nonzero and |lit| <= LIT_IDX_MAX
package uc_loader_pkg;

  localparam int LIT_IDX_MAX = 1000;
  localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;

  typedef enum logic [1:0] {
    UC_ARB_LOAD,
    UC_ARB_RUN,
    UC_ARB_CONFLICT
  } uc_arb_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FIN
  } uc_ld_t;

  // Magnitude is formed one bit wider so the most-negative literal
  // does not wrap back to itself when negated.
  function automatic logic lit_in_range(input logic signed [LIT_W-1:0] lit);
    logic signed [LIT_W:0] ext;
    logic        [LIT_W:0] mag;
    ext = {lit[LIT_W-1], lit};
    mag = ext[LIT_W] ? unsigned'(-ext) : unsigned'(ext);
    return (lit != '0) && (mag <= (LIT_W+1)'(LIT_IDX_MAX));
  endfunction

endpackage

// File: rtl/uc_loader.sv
// uc_loader: fetches the initial unit-clause literal list from memory and
// streams range-checked literals to the unit-clause arbiter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a load (sampled only in IDLE)
//   base_addr, uc_count      list address / length, captured on start
//   mem_req_valid/ready/addr read request port (one request outstanding)
//   mem_rsp_valid/data       read response port (signed literal)
//   mem2uca_valid, mem2uca   accepted literal toward the arbiter, 1 cycle each
//   mem2uca_done             end-of-list pulse
//   busy                     not IDLE
//   err                      sticky: an invalid literal was dropped
//
// Build option: UC_LOADER_ZERO_TERM_EN makes a zero literal terminate the
// list early (uc_count becomes an upper bound) instead of being an error.
module uc_loader
  import uc_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       uc_count,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic signed [LIT_W-1:0] mem_rsp_data,
  output logic                    mem2uca_valid,
  output logic signed [LIT_W-1:0] mem2uca,
  output logic                    mem2uca_done,
  output logic                    busy,
  output logic                    err
);

  uc_ld_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_r, addr_d;
  logic [ADDR_W-1:0]       rem_r, rem_d;
  logic                    err_r, err_d;
  logic                    val_r, val_d;
  logic signed [LIT_W-1:0] lit_r, lit_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      err_r   <= 1'b0;
      val_r   <= 1'b0;
      lit_r   <= '0;
    end else begin
      state_q <= state_d;
      addr_r  <= addr_d;
      rem_r   <= rem_d;
      err_r   <= err_d;
      val_r   <= val_d;
      lit_r   <= lit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_r;
    rem_d   = rem_r;
    err_d   = err_r;
    val_d   = 1'b0;
    lit_d   = lit_r;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = uc_count;
          err_d   = 1'b0;
          state_d = (uc_count == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          addr_d  = addr_r + ADDR_W'(1);
          rem_d   = rem_r - ADDR_W'(1);
          state_d = (rem_r == ADDR_W'(1)) ? FIN : REQ;
`ifdef UC_LOADER_ZERO_TERM_EN
          if (mem_rsp_data == '0) begin
            state_d = FIN;
          end else
`endif
          if (lit_in_range(mem_rsp_data)) begin
            val_d = 1'b1;
            lit_d = mem_rsp_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FIN: begin
        // Hold here while the final literal is on the output so that
        // done lands in the following cycle, never alongside valid.
        if (!val_r) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = addr_r;
  assign mem2uca_valid = val_r;
  assign mem2uca       = lit_r;
  assign mem2uca_done  = (state_q == FIN) && !val_r;
  assign busy          = (state_q != IDLE);
  assign err           = err_r;

endmodule

// File: tb/tb_uc_loader.sv
module tb_uc_loader;
  import uc_loader_pkg::*;

  localparam int ADDR_W = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [ADDR_W-1:0]       uc_count = '0;
  logic                    mem_req_valid;
  logic                    mem_req_ready = 1'b1;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic                    mem_rsp_valid;
  logic signed [LIT_W-1:0] mem_rsp_data;
  logic                    mem2uca_valid;
  logic signed [LIT_W-1:0] mem2uca;
  logic                    mem2uca_done;
  logic                    busy;
  logic                    err;

  // memory model, 1-cycle latency; manual injection for late responses
  logic signed [LIT_W-1:0] mem [0:255];
  logic                    m_rsp = 1'b0;
  logic signed [LIT_W-1:0] m_data = '0;
  logic                    hold_rsp = 1'b0;
  logic                    man_rsp = 1'b0;
  logic signed [LIT_W-1:0] man_data = '0;

  assign mem_rsp_valid = m_rsp | man_rsp;
  assign mem_rsp_data  = man_rsp ? man_data : m_data;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int req_cnt = 0;
  int req_vld_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int overlap = 0;
  int beat_q[$];
  int beat_cyc[$];

  uc_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .uc_count(uc_count), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem2uca_valid(mem2uca_valid), .mem2uca(mem2uca),
    .mem2uca_done(mem2uca_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_rsp <= 1'b0;
    if (!rst && mem_req_valid && mem_req_ready) begin
      req_cnt <= req_cnt + 1;
      if (!hold_rsp) begin
        m_rsp  <= 1'b1;
        m_data <= mem[mem_req_addr[7:0]];
      end
    end
    if (mem_req_valid) req_vld_cyc <= req_vld_cyc + 1;
    if (mem2uca_valid) begin
      beat_q.push_back(int'(mem2uca));
      beat_cyc.push_back(cyc);
    end
    if (mem2uca_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (mem2uca_done && mem2uca_valid) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // leaves the bench at the negedge of cycle t+1
  task automatic do_start(input int base, input int cnt);
    @(negedge clk);
    base_addr = ADDR_W'(base);
    uc_count  = ADDR_W'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int snap);
    int n;
    n = 0;
    while (done_cnt == snap && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == snap) chk({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b0, d0, r0, v0, stable, n;
    mem[10] = 11'sd5;  mem[11] = -11'sd7; mem[12] = 11'sd2;
    mem[20] = 11'sd3;  mem[21] = 11'sd1001; mem[22] = -11'sd4;
    mem[30] = 11'sd1;  mem[31] = 11'sd2;  mem[32] = 11'sd0;
    mem[33] = 11'sd9;  mem[34] = 11'sd9;
    mem[40] = 11'sd6;  mem[41] = 11'sd8;
    mem[50] = -11'sd1000; mem[51] = -11'sd1024; mem[52] = 11'sd1000;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", int'(mem_req_valid), 0);
    chk("rst_req_addr", int'(mem_req_addr), 0);
    chk("rst_valid", int'(mem2uca_valid), 0);
    chk("rst_done", int'(mem2uca_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    // basic 3-word load
    b0 = beat_q.size(); d0 = done_cnt;
    do_start(10, 3);
    chk("t1_req_t1", int'(mem_req_valid), 1);
    chk("t1_req_addr", int'(mem_req_addr), 10);
    wait_done("t1", d0);
    chk("t1_nbeats", beat_q.size() - b0, 3);
    if (beat_q.size() - b0 == 3) begin
      chk("t1_beat0", beat_q[b0], 5);
      chk("t1_beat1", beat_q[b0+1], -7);
      chk("t1_beat2", beat_q[b0+2], 2);
      chk("t1_gap01", beat_cyc[b0+1] - beat_cyc[b0], 2);
      chk("t1_gap12", beat_cyc[b0+2] - beat_cyc[b0+1], 2);
      chk("t1_done_cyc", done_cyc - beat_cyc[b0+2], 1);
    end
    chk("t1_ndone", done_cnt - d0, 1);
    chk("t1_err", int'(err), 0);
    chk("t1_busy", int'(busy), 0);

    // empty list
    v0 = req_vld_cyc; d0 = done_cnt;
    do_start(10, 0);
    chk("t2_done_t1", int'(mem2uca_done), 1);
    @(negedge clk);
    chk("t2_done_gone", int'(mem2uca_done), 0);
    chk("t2_busy", int'(busy), 0);
    chk("t2_no_req", req_vld_cyc - v0, 0);
    chk("t2_ndone", done_cnt - d0, 1);

    // request backpressure
    b0 = beat_q.size(); d0 = done_cnt;
    mem_req_ready = 1'b0;
    do_start(10, 3);
    stable = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_valid && mem_req_addr == 16'd10) stable++;
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    chk("t3_req_stable", stable, 4);
    wait_done("t3", d0);
    chk("t3_nbeats", beat_q.size() - b0, 3);
    if (beat_q.size() - b0 == 3) begin
      chk("t3_beat0", beat_q[b0], 5);
      chk("t3_beat1", beat_q[b0+1], -7);
      chk("t3_beat2", beat_q[b0+2], 2);
    end

    // out-of-range literal dropped
    b0 = beat_q.size(); d0 = done_cnt;
    do_start(20, 3);
    wait_done("t4", d0);
    chk("t4_nbeats", beat_q.size() - b0, 2);
    if (beat_q.size() - b0 == 2) begin
      chk("t4_beat0", beat_q[b0], 3);
      chk("t4_beat1", beat_q[b0+1], -4);
    end
    chk("t4_err", int'(err), 1);
    chk("t4_ndone", done_cnt - d0, 1);

    // magnitude boundaries; new start clears err
    b0 = beat_q.size(); d0 = done_cnt;
    do_start(50, 3);
    chk("t5_err_clr", int'(err), 0);
    wait_done("t5", d0);
    chk("t5_nbeats", beat_q.size() - b0, 2);
    if (beat_q.size() - b0 == 2) begin
      chk("t5_beat0", beat_q[b0], -1000);
      chk("t5_beat1", beat_q[b0+1], 1000);
    end
    chk("t5_err", int'(err), 1);

    // zero literal
    b0 = beat_q.size(); d0 = done_cnt; r0 = req_cnt;
    do_start(30, 5);
    wait_done("t6", d0);
`ifdef UC_LOADER_ZERO_TERM_EN
    chk("t6_nbeats", beat_q.size() - b0, 2);
    chk("t6_nreq", req_cnt - r0, 3);
    chk("t6_err", int'(err), 0);
    if (beat_q.size() - b0 == 2) begin
      chk("t6_beat0", beat_q[b0], 1);
      chk("t6_beat1", beat_q[b0+1], 2);
    end
`else
    chk("t6_nbeats", beat_q.size() - b0, 4);
    chk("t6_nreq", req_cnt - r0, 5);
    chk("t6_err", int'(err), 1);
    if (beat_q.size() - b0 == 4) begin
      chk("t6_beat0", beat_q[b0], 1);
      chk("t6_beat1", beat_q[b0+1], 2);
      chk("t6_beat2", beat_q[b0+2], 9);
      chk("t6_beat3", beat_q[b0+3], 9);
    end
`endif
    chk("t6_ndone", done_cnt - d0, 1);

    // reset while waiting, then a late response
    b0 = beat_q.size(); d0 = done_cnt; r0 = req_cnt;
    hold_rsp = 1'b1;
    do_start(40, 2);
    n = 0;
    while (req_cnt == r0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t7_req_taken", req_cnt - r0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_busy_rst", int'(busy), 0);
    rst = 1'b0;
    man_rsp = 1'b1;
    man_data = 11'sd6;
    @(negedge clk);
    man_rsp = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_no_beat", beat_q.size() - b0, 0);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_idle", int'(busy), 0);
    hold_rsp = 1'b0;
    do_start(40, 2);
    chk("t7_restart_addr", int'(mem_req_addr), 40);
    wait_done("t7", d0);
    chk("t7_nbeats", beat_q.size() - b0, 2);
    if (beat_q.size() - b0 == 2) begin
      chk("t7_beat0", beat_q[b0], 6);
      chk("t7_beat1", beat_q[b0+1], 8);
    end

    chk("done_valid_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
